// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with alignment/range check and timeout
module fetch_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enabled,
  input  logic [31:0]           pc_in,
  output logic                  completed,
  output logic                  busy,
  output logic [31:0]           pc,
  output logic [31:0]           instr_raw,
  output logic [1:0]            fault,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_rdata
);

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [7:0]  LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           pc_cap_q, pc_cap_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  completed_q, completed_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [1:0]            fault_q, fault_d;
  logic                  bad_addr;

  // Misaligned byte address or word address beyond the instruction memory
  assign bad_addr = (pc_in[1:0] != 2'b00) || (pc_in[31:ADDR_WIDTH+2] != '0);

  // Next-state and result logic; results only change on a completing cycle
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    pc_cap_d    = pc_cap_q;
    cnt_d       = cnt_q;
    completed_d = 1'b0;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: begin
        // A start strobe during the completion pulse is dropped, not queued
        if (enabled && !completed_q) begin
          if (bad_addr) begin
            completed_d = 1'b1;
            fault_d     = 2'b01;
            pc_d        = pc_in;
            instr_d     = NOP;
          end else begin
            state_d    = S_WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_in[ADDR_WIDTH+1:2];
            pc_cap_d   = pc_in;
            cnt_d      = 8'd0;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the last allowed cycle beats the timeout
        if (mem_valid && mem_req_q) begin
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          completed_d = 1'b1;
          fault_d     = 2'b00;
          pc_d        = pc_cap_q;
          instr_d     = mem_rdata;
        end else if (cnt_q == LAST_WAIT) begin
          state_d     = S_IDLE;
          mem_req_d   = 1'b0;
          completed_d = 1'b1;
          fault_d     = 2'b10;
          pc_d        = pc_cap_q;
          instr_d     = NOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      pc_cap_q    <= 32'd0;
      cnt_q       <= 8'd0;
      completed_q <= 1'b0;
      pc_q        <= 32'd0;
      instr_q     <= NOP;
      fault_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      pc_cap_q    <= pc_cap_d;
      cnt_q       <= cnt_d;
      completed_q <= completed_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fault_q     <= fault_d;
    end
  end

  assign busy      = (state_q == S_WAIT);
  assign completed = completed_q;
  assign pc        = pc_q;
  assign instr_raw = instr_q;
  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, mem_rdata;
  logic        en_a, en_b, mv_a, mv_b;

  logic        completed_a, busy_a, mem_req_a;
  logic [31:0] pc_a, instr_a;
  logic [1:0]  fault_a;
  logic [9:0]  mem_addr_a;
  logic        completed_b, busy_b, mem_req_b;
  logic [31:0] pc_b, instr_b;
  logic [1:0]  fault_b;
  logic [9:0]  mem_addr_b;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int vectors = 0;
  int miscompares = 0;
  int req_cyc_a = 0;
  int comp_a = 0;
  int comp_b = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(10), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .enabled(en_a), .pc_in(pc_in),
    .completed(completed_a), .busy(busy_a), .pc(pc_a), .instr_raw(instr_a),
    .fault(fault_a), .mem_req(mem_req_a), .mem_addr(mem_addr_a),
    .mem_valid(mv_a), .mem_rdata(mem_rdata)
  );

  fetch_unit #(.ADDR_WIDTH(10)) u_b (
    .clk(clk), .rst(rst), .enabled(en_b), .pc_in(pc_in),
    .completed(completed_b), .busy(busy_b), .pc(pc_b), .instr_raw(instr_b),
    .fault(fault_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_valid(mv_b), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected result whenever a DUT pulses completed
  always @(negedge clk) begin : mon
    exp_t e;
    if (mem_req_a) req_cyc_a++;
    if (completed_a) begin
      comp_a++;
      if (qa.size() == 0) chk("a_unexpected_completed", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_pc", pc_a, e.pc);
        chk("a_instr", instr_a, e.instr);
        chk("a_fault", {30'd0, fault_a}, {30'd0, e.fault});
      end
    end
    if (completed_b) begin
      comp_b++;
      if (qb.size() == 0) chk("b_unexpected_completed", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_pc", pc_b, e.pc);
        chk("b_instr", instr_b, e.instr);
        chk("b_fault", {30'd0, fault_b}, {30'd0, e.fault});
      end
    end
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_completed"}, {31'd0, completed_a}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req_a}, 32'd0);
    chk({tag, "_pc"}, pc_a, 32'd0);
    chk({tag, "_instr"}, instr_a, 32'h00000013);
    chk({tag, "_fault"}, {30'd0, fault_a}, 32'd0);
    chk({tag, "_mem_addr"}, {22'd0, mem_addr_a}, 32'd0);
  endtask

  initial begin
    int r0, c0, n;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; mv_a = 1'b0; mv_b = 1'b0;
    pc_in = 32'd0; mem_rdata = 32'd0;
    repeat (2) tick();
    @(negedge clk);
    chk_reset_a("rst");
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_b_instr", instr_b, 32'h00000013);
    tick();
    rst = 1'b0;
    tick();

    // Aligned fetch, 1-cycle memory
    pc_in = 32'h8; en_a = 1'b1;
    qa.push_back('{pc: 32'h8, instr: 32'h002181B3, fault: 2'b00});
    tick();
    en_a = 1'b0; mv_a = 1'b1; mem_rdata = 32'h002181B3;
    @(negedge clk);
    chk("t30_mem_req", {31'd0, mem_req_a}, 32'd1);
    chk("t30_mem_addr", {22'd0, mem_addr_a}, 32'd2);
    chk("t30_busy", {31'd0, busy_a}, 32'd1);
    chk("t30_early_completed", {31'd0, completed_a}, 32'd0);
    tick();
    mv_a = 1'b0;
    @(negedge clk);
    chk("t30_latency2", {31'd0, completed_a}, 32'd1);
    chk("t30_req_dropped", {31'd0, mem_req_a}, 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("t30_hold_instr", instr_a, 32'h002181B3);
    chk("t30_hold_pc", pc_a, 32'h8);

    // Misaligned; enable held into the completion cycle must be dropped
    tick();
    r0 = req_cyc_a;
    pc_in = 32'h6; en_a = 1'b1;
    qa.push_back('{pc: 32'h6, instr: 32'h00000013, fault: 2'b01});
    tick();
    pc_in = 32'h40;
    @(negedge clk);
    chk("t31_completed", {31'd0, completed_a}, 32'd1);
    tick();
    en_a = 1'b0;
    @(negedge clk);
    chk("t31_ignored_busy", {31'd0, busy_a}, 32'd0);
    chk("t31_no_req", req_cyc_a - r0, 32'd0);

    // Out of range
    tick();
    r0 = req_cyc_a;
    pc_in = 32'h1000; en_a = 1'b1;
    qa.push_back('{pc: 32'h1000, instr: 32'h00000013, fault: 2'b01});
    tick();
    en_a = 1'b0;
    @(negedge clk);
    chk("t32_completed", {31'd0, completed_a}, 32'd1);
    tick();
    @(negedge clk);
    chk("t32_no_req", req_cyc_a - r0, 32'd0);

    // Highest legal address, 2-cycle memory
    tick();
    pc_in = 32'hFFC; en_a = 1'b1;
    qa.push_back('{pc: 32'hFFC, instr: 32'hCAFEF00D, fault: 2'b00});
    tick();
    en_a = 1'b0;
    @(negedge clk);
    chk("top_mem_addr", {22'd0, mem_addr_a}, 32'h3FF);
    tick();
    mv_a = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mv_a = 1'b0;
    tick();

    // Timeout, then stale response ignored
    r0 = req_cyc_a;
    pc_in = 32'h20; en_a = 1'b1;
    qa.push_back('{pc: 32'h20, instr: 32'h00000013, fault: 2'b10});
    tick();
    en_a = 1'b0;
    n = 0;
    while (!completed_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t33_timeout_seen", {31'd0, completed_a}, 32'd1);
    chk("t33_req_cycles", req_cyc_a - r0, 32'd4);
    tick();
    mv_a = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); tick();
    mv_a = 1'b0;
    @(negedge clk);
    chk("t33_stale_req", {31'd0, mem_req_a}, 32'd0);
    chk("t33_stale_instr", instr_a, 32'h00000013);
    chk("t33_stale_fault", {30'd0, fault_a}, 32'd2);
    tick();

    // Data on the final timeout cycle wins
    r0 = req_cyc_a;
    pc_in = 32'h24; en_a = 1'b1;
    qa.push_back('{pc: 32'h24, instr: 32'h11112222, fault: 2'b00});
    tick();
    en_a = 1'b0;
    tick(); tick(); tick();
    mv_a = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mv_a = 1'b0;
    @(negedge clk);
    chk("t22_completed", {31'd0, completed_a}, 32'd1);
    chk("t22_req_cycles", req_cyc_a - r0, 32'd4);
    tick();

    // Latency 5 with a re-pulsed enable during WAIT (long-timeout instance)
    c0 = comp_b;
    pc_in = 32'h4; en_b = 1'b1;
    qb.push_back('{pc: 32'h4, instr: 32'h00A00093, fault: 2'b00});
    tick();
    en_b = 1'b0;
    @(negedge clk);
    chk("t34_mem_addr0", {22'd0, mem_addr_b}, 32'd1);
    tick();
    en_b = 1'b1; pc_in = 32'h10;
    tick();
    en_b = 1'b0;
    @(negedge clk);
    chk("t34_mem_addr1", {22'd0, mem_addr_b}, 32'd1);
    chk("t34_busy", {31'd0, busy_b}, 32'd1);
    tick(); tick();
    mv_b = 1'b1; mem_rdata = 32'h00A00093;
    @(negedge clk);
    chk("t34_mem_addr2", {22'd0, mem_addr_b}, 32'd1);
    tick();
    mv_b = 1'b0;
    @(negedge clk);
    chk("t34_completed", {31'd0, completed_b}, 32'd1);
    tick(); tick();
    chk("t34_single", comp_b - c0, 32'd1);

    // Reset two cycles into WAIT, then a late response
    pc_in = 32'h30; en_a = 1'b1;
    tick();
    en_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mv_a = 1'b1; mem_rdata = 32'h55555555;
    tick(); tick();
    mv_a = 1'b0;
    @(negedge clk);
    chk_reset_a("t35");

    // Reset overrides enable in the same cycle
    tick();
    rst = 1'b1; en_a = 1'b1; pc_in = 32'h8;
    tick();
    rst = 1'b0; en_a = 1'b0;
    @(negedge clk);
    chk("t29_busy", {31'd0, busy_a}, 32'd0);
    chk("t29_mem_req", {31'd0, mem_req_a}, 32'd0);
    tick();
    @(negedge clk);
    chk("t29_completed", {31'd0, completed_a}, 32'd0);

    chk("sb_a_drain", qa.size(), 32'd0);
    chk("sb_b_drain", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
